input_conditioner: RTL
======================

# input_conditioner

Parametrised multi-channel input front end for the traffic light controller. Every asynchronous external input (vehicle sensor, walk request, reprogram) passes through it before reaching the controller FSM. Each channel gets:
- a configurable-depth synchroniser;
- a counter-based debounce filter;
- single-cycle rise and fall pulses;
- a sticky request latch that holds until the consumer clears it.

## Interface

Parameters:
- CHANNELS, default 4: number of independent input channels (≥1).
- SYNC_STAGES, default 2: flip-flop depth of each synchroniser chain (≥2).
- DEBOUNCE_CYCLES, default 4: number of consecutive cycles a synchronised value must differ from the current level before that level changes (≥1).
- CNT_W, default $clog2(DEBOUNCE_CYCLES+1): debounce counter width; derived, not overridden.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately; released synchronously by the upstream reset tree.
- raw_in  input  CHANNELS  unsynchronised external inputs, one bit per channel.
- clear  input  CHANNELS  per-channel clear for req_latched, synchronous, active-high.
- level_out  output  CHANNELS  debounced, synchronised level per channel.
- rise_pulse  output  CHANNELS  one-cycle pulse when level_out goes 0→1.
- fall_pulse  output  CHANNELS  one-cycle pulse when level_out goes 1→0.
- req_latched  output  CHANNELS  sticky request; set by a rise, held until cleared.

## Operation

- Channels are fully independent. Logic is replicated per bit with a generate loop, and no state is shared between channels.
- Synchroniser:
  - chain sync[0..SYNC_STAGES-1];
  - sync[0] ← raw_in;
  - sync[k] ← sync[k-1];
  - s = sync[SYNC_STAGES-1].
- Debounce, one CNT_W-bit counter cnt per channel, evaluated every edge:
  - s == level_out: cnt ← 0.
  - s != level_out and cnt == DEBOUNCE_CYCLES-1: level_out ← s, cnt ← 0.
  - s != level_out otherwise: cnt ← cnt+1.
  - Any cycle with s == level_out restarts the count, so glitches shorter than DEBOUNCE_CYCLES synchronised cycles are rejected.
  - The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Edge pulses:
  - registered, asserted on the same edge that updates level_out;
  - rise_pulse ← (next level = 1) & (level_out = 0);
  - fall_pulse is the converse;
  - both are deasserted on every other edge;
  - rise_pulse and fall_pulse are never high together on a channel.
- Request latch:
  - req_latched ← rise_next | (req_latched & ~clear).
  - A rise coinciding with clear leaves the latch set, so a new request is never lost.
  - clear with no latch set has no effect.
  - A fall does not clear the latch.
- Reset (reset = 0), asynchronous: all sync stages, cnt, level_out, rise_pulse, fall_pulse and req_latched go to 0. A reset during a debounce count discards the count. After release, a raw_in held at 1 produces a normal rise, as level_out is 0.

## Timing

- Reference point: raw_in changes and stays stable before clock edge E1.
- s reflects the change after edge E(SYNC_STAGES).
- level_out updates at edge E(SYNC_STAGES + DEBOUNCE_CYCLES); the rise/fall pulse and the latch set occur on the same edge. Default latency is 6 edges.
- Pulses are exactly one clock wide.
- req_latched clears on the edge after clear is sampled high, i.e. clear is visible one cycle later.
- All outputs are registered; no combinational path from raw_in or clear to any output.

## Test plan

- Reset/defaults:
  - drive reset=0 mid-run with raw_in=4'b1111 and cnt nonzero → all outputs 0 immediately, without a clock edge;
  - release reset → level_out=4'b1111 at the 6th edge after release, rise_pulse=4'b1111 for one cycle.
- Clean edge latency: raw_in[0] 0→1 before E1 and held → level_out[0]=1, rise_pulse[0]=1 and req_latched[0]=1 after E6; rise_pulse[0]=0 after E7. Then 1→0 → fall_pulse[0] one cycle, req_latched[0] stays 1.
- Glitch rejection:
  - raw_in[1] high for 3 cycles then low → level_out[1], rise_pulse[1] and req_latched[1] stay 0;
  - high 3, low 1, high 4 → single rise exactly 4 synchronised cycles after the final rise.
- Latch clear race:
  - req_latched[2]=1, pulse clear[2] → 0 next cycle;
  - a new rise on the same edge as clear[2]=1 → req_latched[2] stays 1.
- Channel independence: staggered toggles on all 4 channels with random glitches → each channel matches a per-channel reference model; no cross-channel effects.
- Parameter sweep: SYNC_STAGES=3, DEBOUNCE_CYCLES=1 and CHANNELS=1 → latency 4 edges; DEBOUNCE_CYCLES=1 passes any single-cycle synchronised change.

Source files
------------

// File: rtl/input_conditioner.sv
// Purpose : per-channel synchroniser, debounce filter, edge pulses and sticky request latch.
// Latency : SYNC_STAGES + DEBOUNCE_CYCLES edges from a stable raw_in change to level_out/pulses/latch.
// Backpr. : none; the consumer clears req_latched at its own pace, and a new rise always wins over clear.
//
// Ports:
//   clock        rising-edge system clock
//   reset        asynchronous active-low reset, clears all state
//   raw_in       unsynchronised external inputs, one bit per channel
//   clear        synchronous active-high clear of req_latched, per channel
//   level_out    debounced, synchronised level
//   rise_pulse   one-cycle pulse on level_out 0->1
//   fall_pulse   one-cycle pulse on level_out 1->0
//   req_latched  sticky request, set by a rise, held until cleared
module input_conditioner #(
  parameter  int CHANNELS        = 4,
  parameter  int SYNC_STAGES     = 2,
  parameter  int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  input  logic [CHANNELS-1:0] clear,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] req_latched
);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   level_q;
    logic                   level_nxt;
    logic                   rise_q;
    logic                   fall_q;
    logic                   req_q;
    logic                   rise_nxt;
    logic                   fall_nxt;
    logic                   sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Count consecutive cycles of disagreement; any agreeing cycle restarts
    // the count, and the count is consumed when the level flips, so it can
    // never run past DEBOUNCE_CYCLES-1.
    always_comb begin
      cnt_nxt   = '0;
      level_nxt = level_q;
      if (sync_s != level_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level_nxt = sync_s;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
    end

    assign rise_nxt = level_nxt & ~level_q;
    assign fall_nxt = ~level_nxt & level_q;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        sync_q  <= '0;
        cnt_q   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        req_q   <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_in[ch]};
        cnt_q   <= cnt_nxt;
        level_q <= level_nxt;
        rise_q  <= rise_nxt;
        fall_q  <= fall_nxt;
        // A rise on the same edge as clear keeps the request so it is never lost.
        req_q   <= rise_nxt | (req_q & ~clear[ch]);
      end
    end

    assign level_out[ch]   = level_q;
    assign rise_pulse[ch]  = rise_q;
    assign fall_pulse[ch]  = fall_q;
    assign req_latched[ch] = req_q;
  end

endmodule
